stopwatch_core_n: RTL and testbench

Parametrised successor to the four-digit stopwatch datapath: a BCD time counter of `DIGITS` digits with up/down (stopwatch/timer) mode, BCD preload, lap freeze and a multiplexed seven-segment driver, in one clock domain with an internal tick prescaler. It sits between board switches/buttons (already synchronised upstream) and the anode/segment pins, replacing the separate divider plus state-machine pair in the board top.

---
 rtl/stopwatch_pkg.sv | 31 +++
 rtl/stopwatch_core_n_if.sv | 31 +++
 rtl/sseg_mux.sv | 56 +++++
 rtl/stopwatch_core_n.sv | 177 +++++++++++++++++
 tb/tb_stopwatch_core_n.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: FSM state encoding,
// the BCD-to-seven-segment table and the tick prescaler derivation.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Active-low segments packed {g,f,e,d,c,b,a}; entry 10 is the blank pattern.
  localparam logic [6:0] SSEG_TAB [0:10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
    7'h7F
  };

  // Non-BCD nibbles are shown blank rather than as garbage.
  function automatic logic [6:0] sseg_of(input logic [3:0] d);
    return (d > 4'd9) ? SSEG_TAB[10] : SSEG_TAB[d];
  endfunction

  // Clock cycles per count tick, never less than one.
  function automatic int div_tick(input int clk_hz, input int tick_hz);
    int d;
    d = clk_hz / tick_hz;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/stopwatch_core_n_if.sv
// Board-side bundle of the stopwatch core: button/switch inputs, display
// pins, status flags and debug visibility of the FSM state and live count.
// Handshake: there is no valid/ready pair here; P and lap are levels whose
// rising edge is the command, ld is a one-cycle strobe, done is a one-cycle
// pulse, and all other outputs are plain levels.
interface stopwatch_core_n_if import stopwatch_pkg::*; #(
  parameter int DIGITS = 4
) ();
  logic                  P;
  logic                  mode;
  logic                  ld;
  logic [4*DIGITS-1:0]   load;
  logic                  lap;
  logic [DIGITS-1:0]     an;
  logic [6:0]            sseg;
  logic                  dp;
  logic                  running;
  logic                  done;
  state_t                dbg_state;
  logic [4*DIGITS-1:0]   dbg_count;

  modport master (
    output P, mode, ld, load, lap,
    input  an, sseg, dp, running, done, dbg_state, dbg_count
  );

  modport slave (
    input  P, mode, ld, load, lap,
    output an, sseg, dp, running, done, dbg_state, dbg_count
  );
endinterface

// File: rtl/sseg_mux.sv
// Multiplexed seven-segment driver: walks the digit index, decodes the
// anode and registers segments/dp so all pins change together.
module sseg_mux import stopwatch_pkg::*; #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100_000,
  parameter int DP_POS      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] i_digits,
  output logic [DIGITS-1:0]   o_an,
  output logic [6:0]          o_sseg,
  output logic                o_dp
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [DIV_W-1:0]  r_div;
  logic [IDX_W-1:0]  r_idx;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_sseg;
  logic              r_dp;
  logic [3:0]        w_digit;

  assign w_digit = i_digits[4*r_idx +: 4];

  // Advance the selected digit once every REFRESH_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_W'(REFRESH_DIV - 1)) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Register the pins from the current index; they trail it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an   <= '1;
      r_sseg <= 7'h7F;
      r_dp   <= 1'b1;
    end else begin
      r_an   <= ~(DIGITS'(1) << r_idx);
      r_sseg <= sseg_of(w_digit);
      r_dp   <= (int'(r_idx) != DP_POS);
    end
  end

  assign o_an   = r_an;
  assign o_sseg = r_sseg;
  assign o_dp   = r_dp;
endmodule

// File: rtl/stopwatch_core_n.sv
// BCD stopwatch/timer core: edge-detected start/stop and lap, tick
// prescaler, up/down ripple BCD counter with preload, lap freeze, and the
// multiplexed display driver.
module stopwatch_core_n import stopwatch_pkg::*; #(
  parameter int DIGITS      = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 100,
  parameter int REFRESH_DIV = 100_000,
  parameter int DP_POS      = 2
) (
  input  logic                   clk,
  input  logic                   R,
  stopwatch_core_n_if.slave      bus
);
  localparam int DIV   = div_tick(CLK_HZ, TICK_HZ);
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW    = 4 * DIGITS;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [CW-1:0]    r_cap, w_cap_nxt;
  logic [PRE_W-1:0] r_pre, w_pre_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_frozen, w_frozen_nxt;
  logic             r_done, w_done_nxt;
  logic             r_p_d, r_lap_d;
  logic             w_p_rise, w_lap_rise, w_tick;
  logic [CW-1:0]    w_inc, w_dec, w_load, w_show;
  logic             w_carry, w_borrow, w_zero, w_dec_zero;

  assign w_p_rise   = bus.P & ~r_p_d;
  assign w_lap_rise = bus.lap & ~r_lap_d;
  assign w_tick     = (r_state == S_RUN) && (r_pre == PRE_W'(DIV - 1));
  assign w_zero     = (r_count == '0);
  assign w_dec_zero = (w_dec == '0);

  // Decimal +1/-1 with ripple carry/borrow, and the clamped preload value.
  always_comb begin
    w_inc    = r_count;
    w_dec    = r_count;
    w_load   = bus.load;
    w_carry  = 1'b1;
    w_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_count[4*i +: 4] >= 4'd9) w_inc[4*i +: 4] = 4'd0;
        else begin
          w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          w_carry = 1'b0;
        end
      end
      if (w_borrow) begin
        if (r_count[4*i +: 4] == 4'd0) w_dec[4*i +: 4] = 4'd9;
        else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          w_borrow = 1'b0;
        end
      end
      if (bus.load[4*i +: 4] > 4'd9) w_load[4*i +: 4] = 4'd9;
    end
  end

  // Next state plus datapath updates; a load strobe overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_cap_nxt    = r_cap;
    w_pre_nxt    = r_pre;
    w_mode_nxt   = r_mode;
    w_frozen_nxt = r_frozen;
    w_done_nxt   = 1'b0;
    if (bus.ld) begin
      w_count_nxt  = w_load;
      w_state_nxt  = S_IDLE;
      w_pre_nxt    = '0;
      w_frozen_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_lap_rise) w_frozen_nxt = 1'b0;
          if (w_p_rise) begin
            w_mode_nxt = bus.mode;
            if (bus.mode && w_zero) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_RUN;
            end
          end
        end
        S_RUN: begin
          w_pre_nxt = w_tick ? '0 : r_pre + PRE_W'(1);
          if (w_lap_rise) begin
            w_frozen_nxt = !r_frozen;
            if (!r_frozen) w_cap_nxt = r_count;
          end
          if (w_tick) begin
            if (!r_mode) w_count_nxt = w_inc;
            else if (!w_zero) w_count_nxt = w_dec;
          end
          if (w_tick && r_mode && !w_zero && w_dec_zero) begin
            w_state_nxt  = S_DONE;
            w_done_nxt   = 1'b1;
            w_frozen_nxt = 1'b0;
          end else if (w_p_rise) begin
            w_state_nxt = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (w_lap_rise) w_frozen_nxt = 1'b0;
          if (w_p_rise) w_state_nxt = S_RUN;
        end
        S_DONE: begin
          if (w_lap_rise) w_frozen_nxt = 1'b0;
          if (w_p_rise) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge R) begin
    if (!R) r_state <= S_IDLE;
    else    r_state <= w_state_nxt;
  end

  // Counter, prescaler, lap capture and done pulse registers.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_count  <= '0;
      r_cap    <= '0;
      r_pre    <= '0;
      r_mode   <= 1'b0;
      r_frozen <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_cap    <= w_cap_nxt;
      r_pre    <= w_pre_nxt;
      r_mode   <= w_mode_nxt;
      r_frozen <= w_frozen_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Previous levels of P and lap for rising-edge detection.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_p_d   <= 1'b0;
      r_lap_d <= 1'b0;
    end else begin
      r_p_d   <= bus.P;
      r_lap_d <= bus.lap;
    end
  end

  assign w_show = r_frozen ? r_cap : r_count;

  sseg_mux #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .DP_POS      (DP_POS)
  ) u_sseg_mux (
    .clk      (clk),
    .rst_n    (R),
    .i_digits (w_show),
    .o_an     (bus.an),
    .o_sseg   (bus.sseg),
    .o_dp     (bus.dp)
  );

  assign bus.running   = (r_state == S_RUN);
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;
  assign bus.dbg_count = r_count;
endmodule

// File: tb/tb_stopwatch_core_n.sv
// Directed bench for stopwatch_core_n with a 10-clock tick and a 4-clock
// display refresh.
module tb_stopwatch_core_n;
  import stopwatch_pkg::*;

  logic clk;
  logic R;
  int   n_cmp;
  int   n_err;
  int   done_cnt;
  int   d0;
  logic [6:0] seg;

  stopwatch_core_n_if #(.DIGITS(4)) bus ();

  stopwatch_core_n #(
    .DIGITS      (4),
    .CLK_HZ      (1000),
    .TICK_HZ     (100),
    .REFRESH_DIV (4),
    .DP_POS      (2)
  ) dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  // Clock and done-pulse monitor.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Wait (bounded) until digit idx is selected, then return its segments.
  task automatic read_digit(input int idx, output logic [6:0] s);
    logic [3:0] target;
    bit found;
    target = ~(4'b0001 << idx);
    found = 0;
    s = 7'h7F;
    for (int i = 0; i < 16; i++) begin
      if (bus.an === target) begin
        s = bus.sseg;
        found = 1;
        break;
      end
      step(1);
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $error("FAIL scan_timeout: observed an %b expected %b", bus.an, target);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; done_cnt = 0;
    bus.P = 0; bus.mode = 0; bus.ld = 0; bus.load = '0; bus.lap = 0;
    R = 1'b1;
    #1 R = 1'b0;
    #2;
    check("rst_an", bus.an, 4'hF);
    check("rst_sseg", bus.sseg, 7'h7F);
    check("rst_dp", bus.dp, 1'b1);
    check("rst_running", bus.running, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_state", bus.dbg_state, S_IDLE);
    check("rst_count", bus.dbg_count, 16'h0000);
    step(2);
    check("rst_hold_an", bus.an, 4'hF);
    R = 1'b1;
    step(1);

    // Start, 1000 clocks = 100 ticks, pause, resume from same prescaler phase.
    bus.P = 1; step(1); bus.P = 0;
    check("start_running", bus.running, 1'b1);
    step(1000);
    check("run_1000", bus.dbg_count, 16'h0100);
    bus.P = 1; step(1); bus.P = 0;
    check("pause_state", bus.dbg_state, S_PAUSE);
    check("pause_running", bus.running, 1'b0);
    step(200);
    check("pause_hold", bus.dbg_count, 16'h0100);
    bus.P = 1; step(1); bus.P = 0;
    check("resume_state", bus.dbg_state, S_RUN);
    step(8);
    check("resume_pre_8", bus.dbg_count, 16'h0100);
    step(1);
    check("resume_pre_9", bus.dbg_count, 16'h0101);

    // Up-count wrap through all nines.
    bus.ld = 1; bus.load = 16'h9998; bus.mode = 0; step(1); bus.ld = 0;
    check("ld_9998", bus.dbg_count, 16'h9998);
    check("ld_idle", bus.dbg_state, S_IDLE);
    d0 = done_cnt;
    bus.P = 1; step(1); bus.P = 0;
    step(10); check("up_9999", bus.dbg_count, 16'h9999);
    step(10); check("up_wrap", bus.dbg_count, 16'h0000);
    step(10); check("up_0001", bus.dbg_count, 16'h0001);
    check("up_no_done", done_cnt, d0);

    // Down-count from 3 reaches zero exactly 30 clocks after start.
    bus.ld = 1; bus.load = 16'h0003; bus.mode = 1; step(1); bus.ld = 0;
    d0 = done_cnt;
    bus.P = 1; step(1); bus.P = 0;
    step(29);
    check("dn_pre_done", bus.done, 1'b0);
    check("dn_count_1", bus.dbg_count, 16'h0001);
    step(1);
    check("dn_done", bus.done, 1'b1);
    check("dn_count_0", bus.dbg_count, 16'h0000);
    check("dn_state", bus.dbg_state, S_DONE);
    step(1);
    check("dn_done_1cyc", bus.done, 1'b0);
    step(50);
    check("dn_sat", bus.dbg_count, 16'h0000);
    check("dn_stay", bus.dbg_state, S_DONE);
    check("dn_one_pulse", done_cnt, d0 + 1);
    bus.P = 1; step(1); bus.P = 0;
    check("done_to_idle", bus.dbg_state, S_IDLE);
    step(1);
    bus.P = 1; step(1); bus.P = 0;
    check("idle_zero_done", bus.done, 1'b1);
    check("idle_zero_state", bus.dbg_state, S_DONE);

    // Clamped preload; ld beats P.
    bus.ld = 1; bus.load = 16'h00A5; step(1); bus.ld = 0;
    check("clamp", bus.dbg_count, 16'h0095);
    bus.ld = 1; bus.P = 1; bus.load = 16'h0012; step(1); bus.ld = 0;
    check("ld_beats_p_state", bus.dbg_state, S_IDLE);
    check("ld_beats_p_count", bus.dbg_count, 16'h0012);
    step(3); bus.P = 0;
    check("ld_beats_p_hold", bus.dbg_state, S_IDLE);

    // Lap freeze: display holds 5 while the count moves on to 9.
    bus.mode = 0;
    bus.ld = 1; bus.load = 16'h0000; step(1); bus.ld = 0;
    bus.P = 1; step(1); bus.P = 0;
    step(50);
    check("lap_pre", bus.dbg_count, 16'h0005);
    bus.lap = 1; step(1); bus.lap = 0;
    step(40);
    check("lap_live", bus.dbg_count, 16'h0009);
    bus.P = 1; step(1); bus.P = 0;
    read_digit(0, seg);
    check("lap_frozen_d0", seg, 7'h12);
    bus.P = 1; step(1); bus.P = 0;
    bus.lap = 1; step(1); bus.lap = 0;
    bus.P = 1; step(1); bus.P = 0;
    check("lap_paused_cnt", bus.dbg_count, 16'h0009);
    read_digit(0, seg);
    check("lap_track_d0", seg, 7'h10);
    read_digit(1, seg);
    check("lap_track_d1", seg, 7'h40);

    // Anode scan order and decimal point position.
    read_digit(0, seg);
    check("scan_an0", bus.an, 4'b1110);
    check("scan_dp0", bus.dp, 1'b1);
    step(4);
    check("scan_an1", bus.an, 4'b1101);
    check("scan_dp1", bus.dp, 1'b1);
    step(4);
    check("scan_an2", bus.an, 4'b1011);
    check("scan_dp2", bus.dp, 1'b0);
    step(4);
    check("scan_an3", bus.an, 4'b0111);
    check("scan_dp3", bus.dp, 1'b1);
    step(4);
    check("scan_wrap", bus.an, 4'b1110);

    // Asynchronous reset in the middle of a run.
    bus.P = 1; step(1); bus.P = 0;
    check("rerun_state", bus.dbg_state, S_RUN);
    step(5);
    #2 R = 1'b0;
    #1;
    check("arst_an", bus.an, 4'hF);
    check("arst_sseg", bus.sseg, 7'h7F);
    check("arst_dp", bus.dp, 1'b1);
    check("arst_running", bus.running, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_state", bus.dbg_state, S_IDLE);
    check("arst_count", bus.dbg_count, 16'h0000);
    R = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
